// File: rtl/axi_stream_strip_header.sv
`default_nettype none
// ============================================================================
//  Module   : axi_stream_strip_header
//  Purpose  : Removes a per-packet programmable number of leading bytes
//             (the header) from an AXI-Stream packet and re-packs the
//             payload. Every output beat except the last is full; the last
//             beat is left-aligned. Byte 0 of a beat is data[DATA_WD-1 -: 8].
//  Optional : define STRIP_HEADER_CAPTURE_EN to expose the stripped header
//             bytes on header_out/header_valid.
//  Ports    :
//    clk, rst_n                 clock, asynchronous active-low reset
//    valid_in/data_in/keep_in/last_in/ready_in     input stream
//    valid_out/data_out/keep_out/last_out/ready_out output stream
//    valid_strip/strip_byte_cnt/ready_strip        per-packet strip command
//    header_out/header_valid    (STRIP_HEADER_CAPTURE_EN only) header bytes,
//                               right-aligned, pulsed when beat 0 is taken
//  Revision : 1.0 - initial release
// ============================================================================
module axi_stream_strip_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_strip,
  input  logic [BYTE_CNT_WD:0]    strip_byte_cnt,
  output logic                    ready_strip
`ifdef STRIP_HEADER_CAPTURE_EN
  ,
  output logic [DATA_WD-1:0]      header_out,
  output logic                    header_valid
`endif
);

  localparam logic [BYTE_CNT_WD:0] c_full_cnt = (BYTE_CNT_WD+1)'(DATA_BYTE_WD);

  // DRAIN holds the final output beat until it is handshaken, so the next
  // command can only be accepted after the packet has fully left.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FIRST  = 3'd1,
    S_STREAM = 3'd2,
    S_FLUSH  = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_rst_done;
  logic [BYTE_CNT_WD:0]    r_n;
  logic [DATA_WD-1:0]      r_buf;
  logic [DATA_BYTE_WD-1:0] r_buf_keep;

  logic                    r_valid_out;
  logic [DATA_WD-1:0]      r_data_out;
  logic [DATA_BYTE_WD-1:0] r_keep_out;
  logic                    r_last_out;

  logic                    w_ready_in;
  logic                    w_ready_strip;
  logic                    w_out_free;
  logic                    w_strip_fire;
  logic [BYTE_CNT_WD:0]    w_n_sat;
  logic [BYTE_CNT_WD+3:0]  w_sh_bits;
  logic [2*DATA_WD-1:0]    w_cat_data;
  logic [2*DATA_BYTE_WD-1:0] w_cat_keep;
  logic [DATA_WD-1:0]      w_merge_data;
  logic [DATA_BYTE_WD-1:0] w_merge_keep;
  logic [DATA_WD-1:0]      w_flush_data;
  logic [DATA_BYTE_WD-1:0] w_flush_keep;
  logic [BYTE_CNT_WD:0]    w_last_cnt;
  logic                    w_last_fits;

  logic                    w_load_out;
  logic [DATA_WD-1:0]      w_load_data;
  logic [DATA_BYTE_WD-1:0] w_load_keep;
  logic                    w_load_last;
  logic [DATA_WD-1:0]      w_load_data_m;
  logic                    w_buf_we;

  assign ready_in    = w_ready_in;
  assign ready_strip = w_ready_strip;
  assign valid_out   = r_valid_out;
  assign data_out    = r_data_out;
  assign keep_out    = r_keep_out;
  assign last_out    = r_last_out;

  // ready_strip stays low until the first clock after reset release.
  assign w_ready_strip = (r_state == S_IDLE) && r_rst_done;
  assign w_strip_fire  = valid_strip && w_ready_strip;
  assign w_out_free    = !r_valid_out || ready_out;
  assign w_n_sat       = (strip_byte_cnt > c_full_cnt) ? c_full_cnt : strip_byte_cnt;
  assign w_sh_bits     = {r_n, 3'b000};

  // Output beat k is bytes N..N+DB-1 of {beat k, beat k+1}.
  assign w_cat_data   = {r_buf, data_in} << w_sh_bits;
  assign w_cat_keep   = {r_buf_keep, keep_in} << r_n;
  assign w_merge_data = w_cat_data[2*DATA_WD-1 -: DATA_WD];
  assign w_merge_keep = w_cat_keep[2*DATA_BYTE_WD-1 -: DATA_BYTE_WD];

  // Residual of the buffered last beat: its bytes N..L-1 moved to byte 0.
  assign w_flush_data = r_buf << w_sh_bits;
  assign w_flush_keep = r_buf_keep << r_n;

  always_comb begin
    w_last_cnt = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      w_last_cnt = w_last_cnt + {{BYTE_CNT_WD{1'b0}}, keep_in[i]};
    end
  end

  // When the last beat holds no more than N bytes, everything left fits in
  // the merged beat and no flush beat is needed.
  assign w_last_fits = (w_last_cnt <= r_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rst_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rst_done <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready_in  = 1'b0;
    w_load_out  = 1'b0;
    w_load_data = w_merge_data;
    w_load_keep = w_merge_keep;
    w_load_last = 1'b0;
    w_buf_we    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_strip_fire) w_state_nxt = S_FIRST;
      end
      S_FIRST: begin
        // Output register is always empty here: IDLE is only reached after
        // the previous packet's last beat was handshaken.
        w_ready_in = 1'b1;
        if (valid_in) begin
          w_buf_we    = 1'b1;
          w_state_nxt = last_in ? S_FLUSH : S_STREAM;
        end
      end
      S_STREAM: begin
        w_ready_in = w_out_free;
        if (valid_in && w_out_free) begin
          w_buf_we   = 1'b1;
          w_load_out = 1'b1;
          if (last_in) begin
            if (w_last_fits) begin
              w_load_last = 1'b1;
              w_state_nxt = S_DRAIN;
            end else begin
              w_state_nxt = S_FLUSH;
            end
          end
        end
      end
      S_FLUSH: begin
        if (w_out_free) begin
          w_load_out  = 1'b1;
          w_load_data = w_flush_data;
          w_load_keep = w_flush_keep;
          w_load_last = 1'b1;
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_valid_out && ready_out) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bytes outside keep are forced to zero so a header-only packet yields
  // all-zero data and stale tail bytes never leak out.
  always_comb begin
    w_load_data_m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      if (w_load_keep[DATA_BYTE_WD-1-i]) begin
        w_load_data_m[DATA_WD-1-8*i -: 8] = w_load_data[DATA_WD-1-8*i -: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n        <= '0;
      r_buf      <= '0;
      r_buf_keep <= '0;
    end else begin
      if (w_strip_fire) r_n <= w_n_sat;
      if (w_buf_we) begin
        r_buf      <= data_in;
        r_buf_keep <= keep_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
      r_keep_out  <= '0;
      r_last_out  <= 1'b0;
    end else if (w_load_out) begin
      r_valid_out <= 1'b1;
      r_data_out  <= w_load_data_m;
      r_keep_out  <= w_load_keep;
      r_last_out  <= w_load_last;
    end else if (ready_out) begin
      r_valid_out <= 1'b0;
    end
  end

`ifdef STRIP_HEADER_CAPTURE_EN
  logic [BYTE_CNT_WD+3:0] w_hdr_sh;
  logic                   w_hdr_fire;

  assign w_hdr_sh     = {c_full_cnt - r_n, 3'b000};
  assign w_hdr_fire   = (r_state == S_FIRST) && valid_in && (r_n != '0);
  assign header_valid = w_hdr_fire;
  assign header_out   = w_hdr_fire ? (data_in >> w_hdr_sh) : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_strip_header.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_stream_strip_header
//  Purpose  : Self-checking bench for axi_stream_strip_header. Packet
//             vectors (command, input beats, expected output beats) live in
//             a table; expected beats go to a scoreboard queue when the
//             packet is driven and are popped as the DUT emits them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_stream_strip_header;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    logic [2:0]       cnt;
    bit               toggle;
    int               nin;
    int               nout;
    beat_t [3:0]      in_b;
    beat_t [3:0]      out_b;
  } pkt_vec_t;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        last_in;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out;
  logic        valid_strip;
  logic [2:0]  strip_byte_cnt;
  logic        ready_strip;
`ifdef STRIP_HEADER_CAPTURE_EN
  logic [31:0] header_out;
  logic        header_valid;
`endif

  axi_stream_strip_header dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_in       (valid_in),
    .data_in        (data_in),
    .keep_in        (keep_in),
    .last_in        (last_in),
    .ready_in       (ready_in),
    .valid_out      (valid_out),
    .data_out       (data_out),
    .keep_out       (keep_out),
    .last_out       (last_out),
    .ready_out      (ready_out),
    .valid_strip    (valid_strip),
    .strip_byte_cnt (strip_byte_cnt),
    .ready_strip    (ready_strip)
`ifdef STRIP_HEADER_CAPTURE_EN
    ,
    .header_out     (header_out),
    .header_valid   (header_valid)
`endif
  );

  int       checks   = 0;
  int       failures = 0;
  beat_t    exp_q[$];
  bit       mon_en    = 1'b0;
  bit       toggle_en = 1'b0;
  logic [31:0] exp_hdr = '0;
  int       hdr_pulses = 0;
  pkt_vec_t vecs [8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Downstream ready: constant 1, or alternating 1,0,1,0 when toggling.
  initial begin
    ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_out = toggle_en ? ~ready_out : 1'b1;
    end
  end

  // Output monitor: scoreboard pops, hold-stability and stall checks.
  initial begin
    beat_t hold;
    beat_t e;
    bit    have_hold;
    have_hold = 1'b0;
    hold      = '0;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        if (have_hold) begin
          checks++;
          if ({data_out, keep_out, last_out} !== hold || valid_out !== 1'b1) begin
            failures++;
            $display("FAIL hold_stable: got v=%b %h/%b/%b required v=1 %h/%b/%b",
                     valid_out, data_out, keep_out, last_out, hold.data, hold.keep, hold.last);
          end
        end
        have_hold = 1'b0;
        if (valid_out && !ready_out) begin
          hold      = '{data: data_out, keep: keep_out, last: last_out};
          have_hold = 1'b1;
          checks++;
          if (ready_in !== 1'b0) begin
            failures++;
            $display("FAIL ready_in_stall: got ready_in=%b required 0", ready_in);
          end
        end
        if (valid_out && ready_out) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL extra_beat: got %h/%b/%b required no beat", data_out, keep_out, last_out);
          end else begin
            e = exp_q.pop_front();
            if (data_out !== e.data || keep_out !== e.keep || last_out !== e.last) begin
              failures++;
              $display("FAIL out_beat: got %h/%b/%b required %h/%b/%b",
                       data_out, keep_out, last_out, e.data, e.keep, e.last);
            end
          end
        end
`ifdef STRIP_HEADER_CAPTURE_EN
        if (header_valid) begin
          hdr_pulses++;
          checks++;
          if (header_out !== exp_hdr) begin
            failures++;
            $display("FAIL header_out: got %h required %h", header_out, exp_hdr);
          end
        end
`endif
      end else begin
        have_hold = 1'b0;
      end
    end
  end

  function automatic beat_t mk(input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t b;
    b.data = d;
    b.keep = k;
    b.last = l;
    return b;
  endfunction

  // Header bytes = top N bytes of beat 0, right-aligned.
  function automatic logic [31:0] hdr_of(input logic [2:0] cnt, input logic [31:0] d);
    int n;
    logic [31:0] h;
    n = (cnt > 3'd4) ? 4 : int'(cnt);
    h = '0;
    for (int i = 0; i < n; i++) h = {h[23:0], d[31-8*i -: 8]};
    return h;
  endfunction

  task automatic send_cmd(input logic [2:0] cnt);
    int cyc = 0;
    valid_strip    = 1'b1;
    strip_byte_cnt = cnt;
    @(negedge clk);
    while (!ready_strip && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!ready_strip) begin
      checks++;
      failures++;
      $display("FAIL cmd_timeout: got ready_strip=%b required 1", ready_strip);
    end
    @(posedge clk);
    #1;
    valid_strip = 1'b0;
  endtask

  task automatic send_beat(input beat_t b);
    int cyc = 0;
    valid_in = 1'b1;
    data_in  = b.data;
    keep_in  = b.keep;
    last_in  = b.last;
    @(negedge clk);
    while (!ready_in && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!ready_in) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout: got ready_in=%b required 1", ready_in);
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic run_pkt(input pkt_vec_t v);
    int cyc = 0;
    toggle_en  = v.toggle;
    exp_hdr    = hdr_of(v.cnt, v.in_b[0].data);
    hdr_pulses = 0;
    for (int i = 0; i < v.nout; i++) exp_q.push_back(v.out_b[i]);
    send_cmd(v.cnt);
    for (int i = 0; i < v.nin; i++) send_beat(v.in_b[i]);
    while (exp_q.size() != 0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d beats outstanding required 0", exp_q.size());
      exp_q.delete();
    end
    toggle_en = 1'b0;
    // Last handshake happens on this edge; DUT must then be idle.
    @(posedge clk);
    #1;
    checks++;
    if (valid_out !== 1'b0 || ready_strip !== 1'b1) begin
      failures++;
      $display("FAIL idle_after_pkt: got valid_out=%b ready_strip=%b required 0/1",
               valid_out, ready_strip);
    end
`ifdef STRIP_HEADER_CAPTURE_EN
    checks++;
    if (hdr_pulses != ((exp_hdr != 0 || v.cnt != 0) ? 1 : 0)) begin
      failures++;
      $display("FAIL header_pulses: got %0d required %0d", hdr_pulses, (v.cnt != 0) ? 1 : 0);
    end
`endif
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    valid_in       = 1'b0;
    data_in        = '0;
    keep_in        = '0;
    last_in        = 1'b0;
    valid_strip    = 1'b0;
    strip_byte_cnt = '0;

    // N=3, four beats, last holds two bytes (merges into last beat).
    vecs[0].cnt = 3'd3; vecs[0].toggle = 1'b0; vecs[0].nin = 4; vecs[0].nout = 3;
    vecs[0].in_b[0]  = mk(32'hAABBCCDD, 4'b1111, 1'b0);
    vecs[0].in_b[1]  = mk(32'hEEFF0011, 4'b1111, 1'b0);
    vecs[0].in_b[2]  = mk(32'h22334455, 4'b1111, 1'b0);
    vecs[0].in_b[3]  = mk(32'hAABB0000, 4'b1100, 1'b1);
    vecs[0].out_b[0] = mk(32'hDDEEFF00, 4'b1111, 1'b0);
    vecs[0].out_b[1] = mk(32'h11223344, 4'b1111, 1'b0);
    vecs[0].out_b[2] = mk(32'h55AABB00, 4'b1110, 1'b1);
    vecs[0].out_b[3] = '0;
    // N=1, same packet: residual needs a flush beat.
    vecs[1] = vecs[0];
    vecs[1].cnt = 3'd1; vecs[1].nout = 4;
    vecs[1].out_b[0] = mk(32'hBBCCDDEE, 4'b1111, 1'b0);
    vecs[1].out_b[1] = mk(32'hFF001122, 4'b1111, 1'b0);
    vecs[1].out_b[2] = mk(32'h334455AA, 4'b1111, 1'b0);
    vecs[1].out_b[3] = mk(32'hBB000000, 4'b1000, 1'b1);
    // N=0 pass-through with downstream stalling every other cycle.
    vecs[2].cnt = 3'd0; vecs[2].toggle = 1'b1; vecs[2].nin = 3; vecs[2].nout = 3;
    vecs[2].in_b[0]  = mk(32'h01020304, 4'b1111, 1'b0);
    vecs[2].in_b[1]  = mk(32'h05060708, 4'b1111, 1'b0);
    vecs[2].in_b[2]  = mk(32'h090A0B00, 4'b1110, 1'b1);
    vecs[2].in_b[3]  = '0;
    vecs[2].out_b[0] = vecs[2].in_b[0];
    vecs[2].out_b[1] = vecs[2].in_b[1];
    vecs[2].out_b[2] = vecs[2].in_b[2];
    vecs[2].out_b[3] = '0;
    // N=4, single full beat: entire packet is header.
    vecs[3].cnt = 3'd4; vecs[3].toggle = 1'b0; vecs[3].nin = 1; vecs[3].nout = 1;
    vecs[3].in_b  = '0;
    vecs[3].out_b = '0;
    vecs[3].in_b[0]  = mk(32'hAABBCCDD, 4'b1111, 1'b1);
    vecs[3].out_b[0] = mk(32'h00000000, 4'b0000, 1'b1);
    // Count 7 saturates to 4: first beat dropped whole.
    vecs[4].cnt = 3'd7; vecs[4].toggle = 1'b0; vecs[4].nin = 2; vecs[4].nout = 1;
    vecs[4].in_b  = '0;
    vecs[4].out_b = '0;
    vecs[4].in_b[0]  = mk(32'h11223344, 4'b1111, 1'b0);
    vecs[4].in_b[1]  = mk(32'h55667788, 4'b1100, 1'b1);
    vecs[4].out_b[0] = mk(32'h55660000, 4'b1100, 1'b1);
    // N=2 with L=2: merged last beat exactly full.
    vecs[5].cnt = 3'd2; vecs[5].toggle = 1'b0; vecs[5].nin = 2; vecs[5].nout = 1;
    vecs[5].in_b  = '0;
    vecs[5].out_b = '0;
    vecs[5].in_b[0]  = mk(32'h01020304, 4'b1111, 1'b0);
    vecs[5].in_b[1]  = mk(32'h05060000, 4'b1100, 1'b1);
    vecs[5].out_b[0] = mk(32'h03040506, 4'b1111, 1'b1);
    // N=3, single beat with L=4 > N.
    vecs[6].cnt = 3'd3; vecs[6].toggle = 1'b0; vecs[6].nin = 1; vecs[6].nout = 1;
    vecs[6].in_b  = '0;
    vecs[6].out_b = '0;
    vecs[6].in_b[0]  = mk(32'hAABBCCDD, 4'b1111, 1'b1);
    vecs[6].out_b[0] = mk(32'hDD000000, 4'b1000, 1'b1);
    // N=2, single beat with L=1 (shorter than header, junk in unkept bytes).
    vecs[7].cnt = 3'd2; vecs[7].toggle = 1'b0; vecs[7].nin = 1; vecs[7].nout = 1;
    vecs[7].in_b  = '0;
    vecs[7].out_b = '0;
    vecs[7].in_b[0]  = mk(32'h12345678, 4'b1000, 1'b1);
    vecs[7].out_b[0] = mk(32'h00000000, 4'b0000, 1'b1);

    // Reset state.
    #1;
    checks++;
    if (valid_out !== 1'b0 || data_out !== 32'h0 || keep_out !== 4'h0 || last_out !== 1'b0 ||
        ready_in !== 1'b0 || ready_strip !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got v=%b d=%h k=%b l=%b rin=%b rstr=%b required all 0",
               valid_out, data_out, keep_out, last_out, ready_in, ready_strip);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (ready_strip !== 1'b1 || ready_in !== 1'b0) begin
      failures++;
      $display("FAIL ready_after_reset: got ready_strip=%b ready_in=%b required 1/0",
               ready_strip, ready_in);
    end
    mon_en = 1'b1;

    for (int t = 0; t < 8; t++) run_pkt(vecs[t]);

    // Reset mid-packet, after beat 1 has produced output beat 0.
    mon_en = 1'b0;
    send_cmd(3'd3);
    send_beat(vecs[0].in_b[0]);
    send_beat(vecs[0].in_b[1]);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 32'hDDEEFF00) begin
      failures++;
      $display("FAIL pre_reset_out: got v=%b d=%h required 1/ddeeff00", valid_out, data_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || data_out !== 32'h0 || keep_out !== 4'h0 || last_out !== 1'b0 ||
        ready_in !== 1'b0 || ready_strip !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got v=%b d=%h k=%b l=%b rin=%b rstr=%b required all 0",
               valid_out, data_out, keep_out, last_out, ready_in, ready_strip);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (ready_strip !== 1'b1 || valid_out !== 1'b0) begin
      failures++;
      $display("FAIL after_mid_reset: got ready_strip=%b valid_out=%b required 1/0",
               ready_strip, valid_out);
    end
    exp_q.delete();
    mon_en = 1'b1;
    run_pkt(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
